multimem_dbuf: RTL and testbench

Single-clock, lane-banked framebuffer RAM with two pages (front/back). It succeeds the dual-clock banked framebuffer and is generalised in subpanel count, bytes per pixel and data width.
- The write side (pixel loader) fills the back page one byte at a time under a valid/ready handshake.
- The read side (row scanner) fetches one word from the front page, all lanes in parallel.
- A page swap is requested at any time and takes effect only at the read side's frame boundary, giving tear-free updates.

---
 rtl/multimem_dbuf_if.sv | 32 +++
 rtl/multimem_dbuf.sv | 162 ++++++++++++++++
 tb/tb_multimem_dbuf.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multimem_dbuf_if.sv
// Write, read and page-swap signals of the double-buffered framebuffer.
// master = loader/scanner side, slave = multimem_dbuf.
interface multimem_dbuf_if #(
  parameter int WA        = 13,
  parameter int ADDR_BITS = 11,
  parameter int LANES     = 4,
  parameter int DW        = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [WA-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  rd_en;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [LANES*DW-1:0]   rd_data;
  logic                  rd_valid;
  logic                  swap_req;
  logic                  frame_end;
  logic                  swap_pending;
  logic                  front_page;
  logic                  clear_busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_en, rd_addr, swap_req, frame_end,
    input  wr_ready, rd_data, rd_valid, swap_pending, front_page, clear_busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_en, rd_addr, swap_req, frame_end,
    output wr_ready, rd_data, rd_valid, swap_pending, front_page, clear_busy
  );
endinterface

// File: rtl/multimem_dbuf.sv
// Two-page lane-banked framebuffer: byte writes to the back page, word reads from the front page,
// swap at frame_end. Define FRAMEBUFFER_CLEAR_EN to zero the new back page after every swap.
module multimem_dbuf #(
  parameter int SUBPANEL_BITS = 1,
  parameter int COLOR_BITS    = 1,
  parameter int ADDR_BITS     = 11,
  parameter int DW            = 8
) (
  input  logic          clk_in,
  input  logic          reset,
  multimem_dbuf_if.slave bus
);
  localparam int LB    = SUBPANEL_BITS + COLOR_BITS;
  localparam int LANES = 2 ** LB;
  localparam int WA    = SUBPANEL_BITS + ADDR_BITS + COLOR_BITS;

  logic                 swap_pending_q, swap_pending_d;
  logic                 front_page_q;
  logic                 wr_ready_q;
  logic                 clear_busy_q;
  logic                 clr_active;
  logic                 swap_fire;
  logic                 accept;

  logic                 wr_vld_q;
  logic [LB-1:0]        wr_lane_q;
  logic [ADDR_BITS-1:0] wr_word_q;
  logic [DW-1:0]        wr_data_q;
  logic                 wr_page_q;

  logic                 rd_s1_q;
  logic [ADDR_BITS-1:0] rd_addr_q;
  logic                 rd_page_q;
  logic                 rd_valid_q;
  wire  [LANES*DW-1:0]  rd_word;

`ifdef FRAMEBUFFER_CLEAR_EN
  // state   | meaning
  // S_IDLE  | normal operation, writes accepted
  // S_CLEAR | zeroing back page, one word per cycle, writes stalled
  typedef enum logic {S_IDLE, S_CLEAR} state_e;
  state_e               state_q;
  logic [ADDR_BITS-1:0] clr_cnt_q;
  logic                 clr_we;
  logic [ADDR_BITS-1:0] clr_word;
  assign clr_active = clear_busy_q;
  assign clr_we     = (state_q == S_CLEAR);
  assign clr_word   = ~clr_cnt_q;
`else
  assign clr_active = 1'b0;
`endif

  assign accept    = bus.wr_valid & wr_ready_q;
  assign swap_fire = (swap_pending_q | bus.swap_req) & bus.frame_end & ~clr_active;

  always_comb begin
    swap_pending_d = swap_pending_q;
    if (swap_fire)         swap_pending_d = 1'b0;
    else if (bus.swap_req) swap_pending_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      swap_pending_q <= 1'b0;
      front_page_q   <= 1'b0;
      wr_ready_q     <= 1'b0;
      clear_busy_q   <= 1'b0;
`ifdef FRAMEBUFFER_CLEAR_EN
      state_q        <= S_IDLE;
      clr_cnt_q      <= '0;
`endif
    end else begin
      swap_pending_q <= swap_pending_d;
      if (swap_fire) front_page_q <= ~front_page_q;
`ifdef FRAMEBUFFER_CLEAR_EN
      case (state_q)
        S_IDLE: begin
          if (swap_fire) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= '1;
            clear_busy_q <= 1'b1;
            wr_ready_q   <= 1'b0;
          end else begin
            wr_ready_q   <= 1'b1;
          end
        end
        S_CLEAR: begin
          // down-counter reaches terminal count on the last word
          if (clr_cnt_q == '0) begin
            state_q      <= S_IDLE;
            clear_busy_q <= 1'b0;
            wr_ready_q   <= 1'b1;
          end else begin
            clr_cnt_q    <= clr_cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
`else
      wr_ready_q   <= 1'b1;
      clear_busy_q <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_vld_q <= 1'b0;
    end else begin
      wr_vld_q <= accept;
      if (accept) begin
        wr_lane_q <= {bus.wr_addr[WA-1 -: SUBPANEL_BITS], bus.wr_addr[COLOR_BITS-1:0]};
        wr_word_q <= bus.wr_addr[COLOR_BITS +: ADDR_BITS];
        wr_data_q <= bus.wr_data;
        wr_page_q <= ~front_page_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_s1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_s1_q    <= bus.rd_en;
      rd_valid_q <= rd_s1_q;
      if (bus.rd_en) begin
        rd_addr_q <= bus.rd_addr;
        rd_page_q <= front_page_q;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] mem [2*2**ADDR_BITS];
    logic [DW-1:0] rd_q;

    // reset in the commit cycle drops the staged write
    always_ff @(posedge clk_in) begin
      if (wr_vld_q && !reset && wr_lane_q == LB'(l))
        mem[{wr_page_q, wr_word_q}] <= wr_data_q;
`ifdef FRAMEBUFFER_CLEAR_EN
      if (clr_we && !reset)
        mem[{~front_page_q, clr_word}] <= '0;
`endif
    end

    always_ff @(posedge clk_in) begin
      if (reset)        rd_q <= '0;
      else if (rd_s1_q) rd_q <= mem[{rd_page_q, rd_addr_q}];
    end

    assign rd_word[l*DW +: DW] = rd_q;
  end

  assign bus.wr_ready     = wr_ready_q;
  assign bus.rd_data      = rd_word;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.front_page   = front_page_q;
  assign bus.clear_busy   = clear_busy_q;
endmodule

// File: tb/tb_multimem_dbuf.sv
// Scoreboard bench for multimem_dbuf: reads push expected word and arrival cycle,
// a negedge monitor pops and compares on every rd_valid.
module tb_multimem_dbuf;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  multimem_dbuf_if #(.WA(13), .ADDR_BITS(11), .LANES(4), .DW(8)) bus();

  multimem_dbuf #(.SUBPANEL_BITS(1), .COLOR_BITS(1), .ADDR_BITS(11), .DW(8)) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && bus.rd_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rd_valid at cycle %0d data=%h", cyc, bus.rd_data);
      end else begin
        mon_e = q.pop_front();
        tests++;
        if (bus.rd_data !== mon_e.data) begin
          fails++;
          $display("FAIL rd_data got=%h exp=%h (cycle %0d)", bus.rd_data, mon_e.data, cyc);
        end
        tests++;
        if (cyc != mon_e.cyc) begin
          fails++;
          $display("FAIL rd_latency got_cycle=%0d exp_cycle=%0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [12:0] addr, input logic [7:0] data);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    while (!bus.wr_ready && n < 5000) begin
      tick();
      n++;
    end
    if (!bus.wr_ready) begin
      tests++; fails++;
      $display("FAIL wr_ready_timeout addr=%h", addr);
    end
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd_issue(input logic [10:0] addr, input logic [31:0] exp);
    exp_t e;
    e.data = exp;
    e.cyc  = cyc + 2;
    q.push_back(e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL rd_timeout pending=%0d", q.size());
      q.delete();
    end
    tick();
  endtask

  task automatic wait_clear();
    int n = 0;
    while (bus.clear_busy && n < 5000) begin
      tick();
      n++;
    end
    if (bus.clear_busy) begin
      tests++; fails++;
      $display("FAIL clear_timeout clear_busy=%b", bus.clear_busy);
    end
  endtask

  task automatic pulse(input logic req, input logic fe);
    bus.swap_req  = req;
    bus.frame_end = fe;
    tick();
    bus.swap_req  = 1'b0;
    bus.frame_end = 1'b0;
  endtask

`ifdef FRAMEBUFFER_CLEAR_EN
  task automatic clear_test();
    int busy_n = 0;
    int low_n  = 0;
    wr_byte(13'h000A, 8'h5A);
    wr_byte(13'h1201, 8'hC3);
    wr_byte(13'h0FFF, 8'h77);
    tick();
    pulse(1'b1, 1'b1);
    chk("clr_front_after_swap1", {31'd0, bus.front_page}, 32'd1);
    while (bus.clear_busy && busy_n < 5000) begin
      busy_n++;
      if (!bus.wr_ready) low_n++;
      if (busy_n == 100) begin
        bus.swap_req  = 1'b1;
        bus.frame_end = 1'b1;
      end
      if (busy_n == 101) begin
        bus.swap_req  = 1'b0;
        bus.frame_end = 1'b0;
        chk("clr_deferred_pending", {31'd0, bus.swap_pending}, 32'd1);
        chk("clr_deferred_front", {31'd0, bus.front_page}, 32'd1);
      end
      tick();
    end
    chk("clr_busy_cycles", busy_n, 32'd2048);
    chk("clr_wr_ready_low_cycles", low_n, 32'd2048);
    chk("clr_pending_after_clear", {31'd0, bus.swap_pending}, 32'd1);
    chk("clr_wr_ready_after_clear", {31'd0, bus.wr_ready}, 32'd1);
    rd_issue(11'h005, 32'h0000005A);
    rd_issue(11'h100, 32'hC3000000);
    rd_issue(11'h7FF, 32'h44337711);
    drain();
    pulse(1'b0, 1'b1);
    chk("clr_front_after_swap2", {31'd0, bus.front_page}, 32'd0);
    wait_clear();
    pulse(1'b1, 1'b1);
    chk("clr_front_after_swap3", {31'd0, bus.front_page}, 32'd1);
    rd_issue(11'h005, 32'h0);
    rd_issue(11'h100, 32'h0);
    rd_issue(11'h7FF, 32'h0);
    drain();
    wait_clear();
  endtask
`endif

  initial begin
    reset         = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.swap_req  = 1'b0;
    bus.frame_end = 1'b0;
    repeat (3) tick();
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_swap_pending", {31'd0, bus.swap_pending}, 32'd0);
    chk("rst_front_page", {31'd0, bus.front_page}, 32'd0);
    chk("rst_clear_busy", {31'd0, bus.clear_busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("wr_ready_rise", {31'd0, bus.wr_ready}, 32'd1);

    // basic write to back page, invisible until swap
    wr_byte(13'h1005, 8'hA5);
    tick();
    rd_issue(11'h002, 32'h00000000);
    drain();
    pulse(1'b1, 1'b0);
    chk("swap_pending_set", {31'd0, bus.swap_pending}, 32'd1);
    chk("front_before_fe", {31'd0, bus.front_page}, 32'd0);
    pulse(1'b0, 1'b1);
    chk("front_after_fe", {31'd0, bus.front_page}, 32'd1);
    chk("pending_after_fe", {31'd0, bus.swap_pending}, 32'd0);
    rd_issue(11'h002, 32'hA5000000);
    drain();

    // back-to-back reads
    rd_issue(11'h000, 32'h00000000);
    rd_issue(11'h001, 32'h00000000);
    rd_issue(11'h002, 32'hA5000000);
    rd_issue(11'h003, 32'h00000000);
    drain();

    // repeated swap_req without frame_end
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    chk("multi_req_pending", {31'd0, bus.swap_pending}, 32'd1);
    chk("multi_req_front", {31'd0, bus.front_page}, 32'd1);
    wait_clear();
    pulse(1'b0, 1'b1);
    chk("multi_req_swap_front", {31'd0, bus.front_page}, 32'd0);
    chk("multi_req_swap_pending", {31'd0, bus.swap_pending}, 32'd0);
    wait_clear();
    pulse(1'b0, 1'b1);
    chk("idle_fe_front", {31'd0, bus.front_page}, 32'd0);
    chk("idle_fe_pending", {31'd0, bus.swap_pending}, 32'd0);

    // lane isolation on word 0x7FF
    wr_byte(13'h0FFE, 8'h11);
    wr_byte(13'h0FFF, 8'h22);
    wr_byte(13'h1FFE, 8'h33);
    wr_byte(13'h1FFF, 8'h44);
    tick();
    rd_issue(11'h7FF, 32'h00000000);
    drain();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    chk("dbl_req_front", {31'd0, bus.front_page}, 32'd1);
    chk("dbl_req_pending", {31'd0, bus.swap_pending}, 32'd0);
    rd_issue(11'h7FF, 32'h44332211);
`ifdef FRAMEBUFFER_CLEAR_EN
    rd_issue(11'h002, 32'h00000000);
`else
    rd_issue(11'h002, 32'hA5000000);
`endif
    drain();

    // reset right after accepting a write drops it and the pending swap
    pulse(1'b1, 1'b0);
    wr_byte(13'h0020, 8'h3C);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_front_page", {31'd0, bus.front_page}, 32'd0);
    chk("rst2_swap_pending", {31'd0, bus.swap_pending}, 32'd0);
    chk("rst2_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst2_clear_busy", {31'd0, bus.clear_busy}, 32'd0);
    rd_issue(11'h010, 32'h00000000);
    drain();

`ifdef FRAMEBUFFER_CLEAR_EN
    clear_test();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
